// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC readout: FSM state encoding, register
// addresses, hit-word field layout and the word decoder.
package tdc_pkg;

  localparam int TDC_DATA_W = 28;

  localparam logic [3:0] RES_REG_FIFO1 = 4'd8;
  localparam logic [3:0] RES_REG_FIFO2 = 4'd9;
  localparam logic [3:0] ADDR_IDLE     = 4'hF;

  localparam int HIT_MSB   = 16;
  localparam int SLOPE_BIT = 17;
  localparam int START_LSB = 18;
  localparam int CHAN_LSB  = 26;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_POLL    = 5'b00010,
    ST_SETUP   = 5'b00100,
    ST_STROBE  = 5'b01000,
    ST_RECOVER = 5'b10000
  } rd_state_e;

  typedef struct packed {
    logic [1:0]  chan;
    logic [7:0]  start;
    logic        slope;
    logic [16:0] hit;
  } tdc_hit_t;

  function automatic tdc_hit_t decode_word(input logic [TDC_DATA_W-1:0] w);
    tdc_hit_t h;
    h.hit   = w[HIT_MSB:0];
    h.slope = w[SLOPE_BIT];
    h.start = w[CHAN_LSB-1:START_LSB];
    h.chan  = w[TDC_DATA_W-1:CHAN_LSB];
    return h;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with a configurable
// value loaded on reset.
module sync_2ff #(
  parameter logic PRESET = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic q_p0;
  logic q_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_p0 <= PRESET;
      q_p1 <= PRESET;
    end else begin
      q_p0 <= d;
      q_p1 <= q_p0;
    end
  end

  assign q = q_p1;

endmodule

// File: rtl/tdc_readout.sv
// TDC result readout: polls the two FIFO empty flags, reads hit words from
// result registers 8/9 with CSN/RDN strobes and offers them on valid/ready.
module tdc_readout
  import tdc_pkg::*;
#(
  parameter int RD_LOW_CYC  = 2,
  parameter int RD_HIGH_CYC = 3,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  init_done,
  input  logic                  ef1,
  input  logic                  ef2,
  input  logic [TDC_DATA_W-1:0] tdc_data_in,
  output logic [3:0]            tdc_addr,
  output logic                  tdc_csn,
  output logic                  tdc_rdn,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_fifo,
  output logic [16:0]           res_hit,
  output logic                  res_slope,
  output logic [7:0]            res_start,
  output logic [1:0]            res_chan,
  output logic [CNT_W-1:0]      rd_count
);

  localparam logic [3:0] LOW_LAST  = 4'(RD_LOW_CYC - 1);
  localparam logic [3:0] HIGH_LAST = 4'(RD_HIGH_CYC - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  rd_state_e  state, state_nxt;
  logic [3:0] phase;
  logic       ef1_s, ef2_s;
  logic       sel_fifo;
  logic       start_read;
  logic       capture;
  logic       cur_fifo;
  logic       rr_ptr;
  logic [3:0] addr_q;
  tdc_hit_t   res_q;

  sync_2ff #(.PRESET(1'b1)) u_sync_ef1 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (ef1),
    .q       (ef1_s)
  );

  sync_2ff #(.PRESET(1'b1)) u_sync_ef2 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (ef2),
    .q       (ef2_s)
  );

  // With both FIFOs holding data the pointer decides; otherwise the one that has data.
  assign sel_fifo = (!ef1_s && !ef2_s) ? rr_ptr : ef1_s;

  always_comb begin
    state_nxt  = state;
    start_read = 1'b0;
    capture    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (init_done) state_nxt = ST_POLL;
      end
      ST_POLL: begin
        if (!init_done) begin
          state_nxt = ST_IDLE;
        end else if (!res_valid && (!ef1_s || !ef2_s)) begin
          start_read = 1'b1;
          state_nxt  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_nxt = ST_STROBE;
      end
      ST_STROBE: begin
        if (phase == LOW_LAST) begin
          capture   = 1'b1;
          state_nxt = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        // A read in flight always finishes its recovery before init_done is honoured.
        if (phase == HIGH_LAST) state_nxt = init_done ? ST_POLL : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      phase <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        phase <= 4'd0;
      else if (state == ST_STROBE || state == ST_RECOVER)
        phase <= phase + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= ADDR_IDLE;
      cur_fifo <= 1'b0;
      rr_ptr   <= 1'b0;
    end else begin
      if (start_read) begin
        addr_q   <= sel_fifo ? RES_REG_FIFO2 : RES_REG_FIFO1;
        cur_fifo <= sel_fifo;
      end else if (state_nxt == ST_IDLE) begin
        addr_q <= ADDR_IDLE;
      end
      if (capture) rr_ptr <= ~cur_fifo;
    end
  end

  // Result register and counter: loaded on the edge that ends the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid <= 1'b0;
      res_fifo  <= 1'b0;
      res_q     <= '0;
      rd_count  <= '0;
    end else begin
      if (capture) begin
        res_valid <= 1'b1;
        res_fifo  <= cur_fifo;
        res_q     <= decode_word(tdc_data_in);
        rd_count  <= sat_inc(rd_count);
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign tdc_addr  = addr_q;
  assign tdc_csn   = (state != ST_STROBE);
  assign tdc_rdn   = (state != ST_STROBE);
  assign res_hit   = res_q.hit;
  assign res_slope = res_q.slope;
  assign res_start = res_q.start;
  assign res_chan  = res_q.chan;

endmodule

// File: tb/tb_tdc_readout.sv
// Directed bench for tdc_readout: a small TDC model with two result FIFOs
// feeds the DUT; a scoreboard holds the words in the order they must emerge.
module tb_tdc_readout;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        init_done;
  logic        ef1, ef2;
  logic [27:0] tdc_data_in;
  logic [3:0]  tdc_addr;
  logic        tdc_csn, tdc_rdn;
  logic        res_valid, res_ready;
  logic        res_fifo;
  logic [16:0] res_hit;
  logic        res_slope;
  logic [7:0]  res_start;
  logic [1:0]  res_chan;
  logic [15:0] rd_count;

  logic [3:0]  addr4;
  logic        csn4, rdn4, valid4, fifo4, slope4;
  logic [16:0] hit4;
  logic [7:0]  start4;
  logic [1:0]  chan4;
  logic [3:0]  rd_count4;

  always #5 clk = ~clk;

  tdc_readout dut (
    .clk(clk), .reset_n(reset_n), .init_done(init_done), .ef1(ef1), .ef2(ef2),
    .tdc_data_in(tdc_data_in), .tdc_addr(tdc_addr), .tdc_csn(tdc_csn), .tdc_rdn(tdc_rdn),
    .res_valid(res_valid), .res_ready(res_ready), .res_fifo(res_fifo), .res_hit(res_hit),
    .res_slope(res_slope), .res_start(res_start), .res_chan(res_chan), .rd_count(rd_count)
  );

  tdc_readout #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .init_done(init_done), .ef1(ef1), .ef2(ef2),
    .tdc_data_in(tdc_data_in), .tdc_addr(addr4), .tdc_csn(csn4), .tdc_rdn(rdn4),
    .res_valid(valid4), .res_ready(res_ready), .res_fifo(fifo4), .res_hit(hit4),
    .res_slope(slope4), .res_start(start4), .res_chan(chan4), .rd_count(rd_count4)
  );

  typedef struct packed {
    logic        fifo;
    logic [27:0] word;
  } exp_t;

  exp_t        sb[$];
  logic [27:0] q1[$];
  logic [27:0] q2[$];
  int          n1 = 0, n2 = 0;
  logic [27:0] head1 = '0, head2 = '0;

  assign ef1 = (n1 == 0);
  assign ef2 = (n2 == 0);
  assign tdc_data_in = (tdc_addr == 4'd9) ? head2 : head1;

  int n_pass = 0, n_total = 0, n_fail = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int low_len = 0;
  int last_start = -1;
  bit per_en = 1'b0;
  logic csn_prev = 1'b1, rdn_prev = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic f, input logic [27:0] w);
    sb.push_back({f, w});
    if (f) begin
      q2.push_back(w); n2 = q2.size(); head2 = q2[0];
    end else begin
      q1.push_back(w); n1 = q1.size(); head1 = q1[0];
    end
  endtask

  always @(posedge clk) cyc++;

  // TDC model pops on RDN release; strobe and handshake monitors.
  always @(negedge clk) begin
    if (rdn_prev === 1'b0 && tdc_rdn === 1'b1) begin
      if (tdc_addr == 4'd9 && q2.size() > 0) begin
        void'(q2.pop_front()); n2 = q2.size(); head2 = (n2 > 0) ? q2[0] : '0;
      end else if (tdc_addr == 4'd8 && q1.size() > 0) begin
        void'(q1.pop_front()); n1 = q1.size(); head1 = (n1 > 0) ? q1[0] : '0;
      end
    end
    if (tdc_csn === 1'b0) begin
      if (csn_prev !== 1'b0) begin
        strobe_cnt++;
        check("strobe_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0)
          check("strobe_addr", 32'(tdc_addr), sb[0].fifo ? 32'd9 : 32'd8);
        check("rdn_with_csn", 32'(tdc_rdn), 32'd0);
        if (per_en && last_start >= 0) check("read_period", 32'(cyc - last_start), 32'd7);
        last_start = cyc;
      end
      low_len++;
    end else if (csn_prev === 1'b0) begin
      check("strobe_len", 32'(low_len), 32'd2);
      low_len = 0;
    end
    csn_prev = tdc_csn;
    rdn_prev = tdc_rdn;
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      check("result_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("res_fifo",  32'(res_fifo),  32'(e.fifo));
        check("res_hit",   32'(res_hit),   32'(e.word[16:0]));
        check("res_slope", 32'(res_slope), 32'(e.word[17]));
        check("res_start", 32'(res_start), 32'(e.word[25:18]));
        check("res_chan",  32'(res_chan),  32'(e.word[27:26]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
  endtask

  task automatic wait_sb_empty(input string tag, input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    @(negedge clk);
    while (res_valid !== 1'b1 && n < max) begin
      @(negedge clk); n++;
    end
    check(tag, 32'(res_valid), 32'd1);
  endtask

  task automatic wait_csn_low(input string tag, input int max);
    int n = 0;
    @(negedge clk);
    while (tdc_csn !== 1'b0 && n < max) begin
      @(negedge clk); n++;
    end
    check(tag, 32'(tdc_csn), 32'd0);
  endtask

  initial begin
    int sc;
    int bad;
    logic [16:0] held_hit;
    logic [7:0]  held_start;
    logic [27:0] w;

    reset_n = 1'b0; init_done = 1'b0; res_ready = 1'b1;
    tick(3);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_addr",  32'(tdc_addr),  32'hF);
    check("rst_csn",   32'(tdc_csn),   32'd1);
    check("rst_rdn",   32'(tdc_rdn),   32'd1);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_count", 32'(rd_count),  32'd0);
    check("rst_fields", {res_chan, res_start, res_slope, res_fifo, res_hit[12:0]}, 32'd0);
    tick(50);
    check("no_strobe_idle", 32'(strobe_cnt), 32'd0);

    // Single word from FIFO1
    init_done = 1'b1;
    push_word(1'b0, 28'hA543210);
    wait_valid("single_valid", 40);
    check("single_chan",  32'(res_chan),  32'd2);
    check("single_start", 32'(res_start), 32'h95);
    check("single_slope", 32'(res_slope), 32'd0);
    check("single_hit",   32'(res_hit),   32'h03210);
    check("single_fifo",  32'(res_fifo),  32'd0);
    wait_sb_empty("single_drain", 40);
    check("single_count", 32'(rd_count), 32'd1);

    // Both FIFOs busy: alternate from a fresh pointer
    pulse_reset();
    per_en = 1'b1; last_start = -1;
    for (int i = 0; i < 3; i++) begin
      push_word(1'b0, 28'h1000000 + 28'(i));
      push_word(1'b1, 28'h2000000 + 28'(i * 16));
    end
    wait_sb_empty("alt_drain", 100);
    per_en = 1'b0;
    check("alt_count",  32'(rd_count),  32'd6);
    check("alt_count4", 32'(rd_count4), 32'd6);

    // Back-pressure holds the result and blocks further reads
    res_ready = 1'b0;
    push_word(1'b0, 28'h5ABCDE7);
    push_word(1'b0, 28'h3C0FFEE);
    wait_valid("bp_valid", 40);
    sc = strobe_cnt; held_hit = res_hit; held_start = res_start;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_hit !== held_hit || res_start !== held_start) bad++;
    end
    check("bp_hold", 32'(bad), 32'd0);
    check("bp_no_strobe", 32'(strobe_cnt - sc), 32'd0);
    tick(1);
    res_ready = 1'b1;
    tick(1);
    res_ready = 1'b0;
    wait_valid("bp_next_valid", 40);
    check("bp_next_strobe", 32'(strobe_cnt - sc), 32'd1);
    res_ready = 1'b1;
    wait_sb_empty("bp_drain", 40);

    // init_done falls in the middle of a strobe
    push_word(1'b1, 28'hFFFFFFF);
    wait_csn_low("drop_strobe", 40);
    init_done = 1'b0;
    wait_sb_empty("drop_drain", 40);
    repeat (10) @(negedge clk);
    check("drop_idle_addr", 32'(tdc_addr), 32'hF);
    check("drop_idle_csn",  32'(tdc_csn),  32'd1);
    sc = strobe_cnt;
    push_word(1'b0, 28'h0000001);
    repeat (20) @(negedge clk);
    check("idle_no_read", 32'(strobe_cnt - sc), 32'd0);
    init_done = 1'b1;
    wait_sb_empty("idle_resume", 40);
    check("drop_count", 32'(rd_count), 32'd10);

    // Counter saturation on the narrow build
    pulse_reset();
    for (int i = 0; i < 17; i++) begin
      w = 28'($urandom);
      push_word(1'b0, w);
    end
    wait_sb_empty("sat_drain", 17 * 8 + 40);
    check("sat_count16", 32'(rd_count),  32'd17);
    check("sat_count4",  32'(rd_count4), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
